// File: rtl/master_arbiter.sv
// master_arbiter: round-robin arbiter sharing one master bus between two requesters, with stall timeout.
module master_arbiter #(
  parameter int MASTER_ADDR_WIDTH = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk_proc,
  input  logic                         reset,
  input  logic [MASTER_ADDR_WIDTH-1:0] r0_addr_i,
  input  logic                         r0_wr_i,
  input  logic                         r0_rd_i,
  input  logic [31:0]                  r0_datawr_i,
  output logic [31:0]                  r0_datard_o,
  output logic                         r0_waitreq_o,
  input  logic [MASTER_ADDR_WIDTH-1:0] r1_addr_i,
  input  logic                         r1_wr_i,
  input  logic                         r1_rd_i,
  input  logic [31:0]                  r1_datawr_i,
  output logic [31:0]                  r1_datard_o,
  output logic                         r1_waitreq_o,
  output logic [MASTER_ADDR_WIDTH-1:0] master_addr_o,
  output logic                         master_wr_o,
  output logic                         master_rd_o,
  output logic [31:0]                  master_datawr_o,
  input  logic [31:0]                  master_datard_i,
  input  logic                         master_waitreq,
  output logic                         timeout_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic granted, sel, wr_s, rd_s, pend, done, abort, fire, r0_p, r1_p;
  logic [31:0] rsp;
  always_comb begin
    granted = state_q != IDLE;
    sel = state_q == GRANT1;
    wr_s = sel ? r1_wr_i : r0_wr_i;
    rd_s = sel ? r1_rd_i : r0_rd_i;
    pend = wr_s | rd_s;
    r0_p = r0_wr_i | r0_rd_i;
    r1_p = r1_wr_i | r1_rd_i;
    master_wr_o = granted & wr_s;
    master_rd_o = granted & rd_s & ~wr_s;
    master_addr_o = granted ? (sel ? r1_addr_i : r0_addr_i) : '0;
    master_datawr_o = granted ? (sel ? r1_datawr_i : r0_datawr_i) : '0;
    done = granted & pend & ~master_waitreq;
    abort = (TIMEOUT > 0) && granted && pend && master_waitreq && cnt_q == CW'(TIMEOUT - 1);
    fire = done | abort;
    rsp = done ? master_datard_i : 32'hDEADBEEF;
    r0_waitreq_o = ~(fire & ~sel);
    r1_waitreq_o = ~(fire & sel);
    r0_datard_o = (fire & ~sel) ? rsp : '0;
    r1_datard_o = (fire & sel) ? rsp : '0;
    timeout_d = timeout_q | abort;
    timeout_o = timeout_q;
    // IDLE clears the counter so every grant starts from zero
    cnt_d = !granted ? '0 : (master_waitreq && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
    state_d = state_q;
    last_d = last_q;
    if (!granted) begin
      if (r0_p && (!r1_p || last_q)) begin
        state_d = GRANT0;
        last_d = 1'b0;
      end else if (r1_p) begin
        state_d = GRANT1;
        last_d = 1'b1;
      end
    end else if (!pend || fire) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_proc or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_master_arbiter.sv
// tb_master_arbiter: directed self-checking bench for master_arbiter (TIMEOUT=8).
module tb_master_arbiter;
  logic clk_proc = 1'b0, reset = 1'b1;
  logic [31:0] r0_addr_i = '0, r1_addr_i = '0, r0_datawr_i = '0, r1_datawr_i = '0;
  logic r0_wr_i = 0, r0_rd_i = 0, r1_wr_i = 0, r1_rd_i = 0;
  logic [31:0] r0_datard_o, r1_datard_o, master_addr_o, master_datawr_o;
  logic [31:0] master_datard_i = '0;
  logic r0_waitreq_o, r1_waitreq_o, master_wr_o, master_rd_o, timeout_o;
  logic master_waitreq = 1'b0;
  int checks = 0, errors = 0;
  master_arbiter #(.MASTER_ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .clk_proc(clk_proc), .reset(reset),
    .r0_addr_i(r0_addr_i), .r0_wr_i(r0_wr_i), .r0_rd_i(r0_rd_i), .r0_datawr_i(r0_datawr_i),
    .r0_datard_o(r0_datard_o), .r0_waitreq_o(r0_waitreq_o),
    .r1_addr_i(r1_addr_i), .r1_wr_i(r1_wr_i), .r1_rd_i(r1_rd_i), .r1_datawr_i(r1_datawr_i),
    .r1_datard_o(r1_datard_o), .r1_waitreq_o(r1_waitreq_o),
    .master_addr_o(master_addr_o), .master_wr_o(master_wr_o), .master_rd_o(master_rd_o),
    .master_datawr_o(master_datawr_o), .master_datard_i(master_datard_i),
    .master_waitreq(master_waitreq), .timeout_o(timeout_o));
  always #5 clk_proc = ~clk_proc;
  task automatic tick;
    @(posedge clk_proc);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({master_wr_o, master_rd_o, master_addr_o, master_datawr_o} !== 66'd0) begin errors++; $display("FAIL reset_master got wr=%b rd=%b addr=%h expected zeros", master_wr_o, master_rd_o, master_addr_o); end
    checks++;
    if ({r0_waitreq_o, r1_waitreq_o, timeout_o} !== 3'b110) begin errors++; $display("FAIL reset_flags got %b expected 110", {r0_waitreq_o, r1_waitreq_o, timeout_o}); end
    checks++;
    if ({r0_datard_o, r1_datard_o} !== 64'd0) begin errors++; $display("FAIL reset_datard got %h %h expected 0", r0_datard_o, r1_datard_o); end
    tick();
    reset = 1'b0;
  endtask
  task automatic test_write;
    tick();
    r0_addr_i = 32'h10; r0_datawr_i = 32'hA5A5A5A5; r0_wr_i = 1; master_waitreq = 0;
    #1;
    checks++;
    if ({master_wr_o, r0_waitreq_o} !== 2'b01) begin errors++; $display("FAIL write_T got wr=%b wq=%b expected 0 1", master_wr_o, r0_waitreq_o); end
    tick();
    checks++;
    if ({master_wr_o, master_rd_o, master_addr_o, master_datawr_o} !== {2'b10, 32'h10, 32'hA5A5A5A5}) begin errors++; $display("FAIL write_bus got wr=%b rd=%b addr=%h data=%h expected 1 0 10 a5a5a5a5", master_wr_o, master_rd_o, master_addr_o, master_datawr_o); end
    checks++;
    if ({r0_waitreq_o, r1_waitreq_o} !== 2'b01) begin errors++; $display("FAIL write_done got %b expected 01", {r0_waitreq_o, r1_waitreq_o}); end
    tick();
    r0_wr_i = 0;
    #1;
    checks++;
    if ({master_wr_o, r0_waitreq_o} !== 2'b01) begin errors++; $display("FAIL write_idle got wr=%b wq=%b expected 0 1", master_wr_o, r0_waitreq_o); end
  endtask
  task automatic test_contention;
    do_reset();
    r0_addr_i = 32'h100; r1_addr_i = 32'h200; master_datard_i = 32'h1234; master_waitreq = 0;
    r0_rd_i = 1; r1_rd_i = 1;
    tick();
    checks++;
    if ({master_rd_o, master_addr_o, r0_waitreq_o, r0_datard_o, r1_waitreq_o, r1_datard_o} !== {1'b1, 32'h100, 1'b0, 32'h1234, 1'b1, 32'h0}) begin errors++; $display("FAIL cont_r0_first got rd=%b addr=%h wq0=%b d0=%h wq1=%b d1=%h", master_rd_o, master_addr_o, r0_waitreq_o, r0_datard_o, r1_waitreq_o, r1_datard_o); end
    tick();
    r0_rd_i = 0;
    #1;
    checks++;
    if ({master_rd_o, r1_waitreq_o} !== 2'b01) begin errors++; $display("FAIL cont_idle got rd=%b wq1=%b expected 0 1", master_rd_o, r1_waitreq_o); end
    tick();
    checks++;
    if ({master_rd_o, master_addr_o, r1_waitreq_o, r1_datard_o, r0_waitreq_o} !== {1'b1, 32'h200, 1'b0, 32'h1234, 1'b1}) begin errors++; $display("FAIL cont_r1_second got rd=%b addr=%h wq1=%b d1=%h wq0=%b", master_rd_o, master_addr_o, r1_waitreq_o, r1_datard_o, r0_waitreq_o); end
    tick();
    r1_rd_i = 0;
    r0_rd_i = 1; r1_rd_i = 1;
    tick();
    checks++;
    if ({master_addr_o, r0_waitreq_o} !== {32'h100, 1'b0}) begin errors++; $display("FAIL cont2_r0 got addr=%h wq0=%b expected 100 0", master_addr_o, r0_waitreq_o); end
    tick();
    tick();
    checks++;
    if ({master_addr_o, r1_waitreq_o, r0_waitreq_o} !== {32'h200, 2'b01}) begin errors++; $display("FAIL cont2_r1_rr got addr=%h wq1=%b wq0=%b expected 200 0 1", master_addr_o, r1_waitreq_o, r0_waitreq_o); end
    tick();
    r1_rd_i = 0;
    tick();
    checks++;
    if ({master_addr_o, r0_waitreq_o} !== {32'h100, 1'b0}) begin errors++; $display("FAIL cont2_r0_again got addr=%h wq0=%b expected 100 0", master_addr_o, r0_waitreq_o); end
    tick();
    r0_rd_i = 0;
  endtask
  task automatic test_stall;
    r1_addr_i = 32'h300; r1_rd_i = 1; master_waitreq = 1; master_datard_i = 32'hCAFE0001;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({master_rd_o, r1_waitreq_o, r1_datard_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL stall_cyc%0d got rd=%b wq1=%b d1=%h expected 1 1 0", i, master_rd_o, r1_waitreq_o, r1_datard_o); end
      tick();
    end
    master_waitreq = 0;
    #1;
    checks++;
    if ({master_rd_o, r1_waitreq_o, r1_datard_o} !== {2'b10, 32'hCAFE0001}) begin errors++; $display("FAIL stall_done got rd=%b wq1=%b d1=%h expected 1 0 cafe0001", master_rd_o, r1_waitreq_o, r1_datard_o); end
    tick();
    r1_rd_i = 0;
  endtask
  task automatic test_timeout;
    r0_addr_i = 32'h40; r0_wr_i = 1; master_waitreq = 1;
    tick();
    for (int i = 1; i < 8; i++) begin
      checks++;
      if ({master_wr_o, r0_waitreq_o, timeout_o} !== 3'b110) begin errors++; $display("FAIL to_wait%0d got wr=%b wq0=%b to=%b expected 1 1 0", i, master_wr_o, r0_waitreq_o, timeout_o); end
      tick();
    end
    checks++;
    if ({r0_waitreq_o, r0_datard_o, timeout_o} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin errors++; $display("FAIL to_abort got wq0=%b d0=%h to=%b expected 0 deadbeef 0", r0_waitreq_o, r0_datard_o, timeout_o); end
    tick();
    r0_wr_i = 0;
    #1;
    checks++;
    if ({timeout_o, r0_waitreq_o, master_wr_o} !== 3'b110) begin errors++; $display("FAIL to_sticky got to=%b wq0=%b wr=%b expected 1 1 0", timeout_o, r0_waitreq_o, master_wr_o); end
    master_waitreq = 0; r1_rd_i = 1; master_datard_i = 32'h55;
    tick();
    checks++;
    if ({r1_waitreq_o, r1_datard_o, timeout_o} !== {1'b0, 32'h55, 1'b1}) begin errors++; $display("FAIL to_next got wq1=%b d1=%h to=%b expected 0 55 1", r1_waitreq_o, r1_datard_o, timeout_o); end
    tick();
    r1_rd_i = 0;
  endtask
  task automatic test_drop;
    r0_wr_i = 1; master_waitreq = 1;
    tick();
    r0_wr_i = 0;
    #1;
    checks++;
    if ({master_wr_o, r0_waitreq_o} !== 2'b01) begin errors++; $display("FAIL drop_strobe got wr=%b wq0=%b expected 0 1", master_wr_o, r0_waitreq_o); end
    tick();
    r1_rd_i = 1; master_waitreq = 0;
    tick();
    checks++;
    if ({r1_waitreq_o, master_rd_o} !== 2'b01) begin errors++; $display("FAIL drop_next got wq1=%b rd=%b expected 0 1", r1_waitreq_o, master_rd_o); end
    tick();
    r1_rd_i = 0;
  endtask
  task automatic test_reset_mid;
    r1_rd_i = 1; master_waitreq = 1;
    tick();
    checks++;
    if (master_rd_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre got rd=%b expected 1", master_rd_o); end
    #2;
    reset = 1;
    #1;
    checks++;
    if ({master_rd_o, r1_waitreq_o, timeout_o} !== 3'b010) begin errors++; $display("FAIL rstmid_async got rd=%b wq1=%b to=%b expected 0 1 0", master_rd_o, r1_waitreq_o, timeout_o); end
    r1_rd_i = 0;
    tick();
    reset = 0;
    tick();
    checks++;
    if ({master_rd_o, r1_waitreq_o, timeout_o} !== 3'b010) begin errors++; $display("FAIL rstmid_after got rd=%b wq1=%b to=%b expected 0 1 0", master_rd_o, r1_waitreq_o, timeout_o); end
  endtask
  task automatic test_wr_rd;
    r0_wr_i = 1; r0_rd_i = 1; master_waitreq = 0;
    tick();
    checks++;
    if ({master_wr_o, master_rd_o, r0_waitreq_o} !== 3'b100) begin errors++; $display("FAIL wr_rd got wr=%b rd=%b wq0=%b expected 1 0 0", master_wr_o, master_rd_o, r0_waitreq_o); end
    tick();
    r0_wr_i = 0; r0_rd_i = 0;
  endtask
  initial begin
    test_reset();
    test_write();
    test_contention();
    test_stall();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_wr_rd();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
